rs_decode_arbiter: RTL and testbench

Shares one `rs_decode_wrapper` Reed-Solomon (15-byte codeword) decoder between `NUM_REQ` requesters. Each requester offers a 120-bit codeword through a valid/ready handshake. The block picks a requester round-robin, sequences the decoder through launch, wait and capture, and returns `error_pos` and `with_error` to that requester as a one-cycle response pulse. It sits between the packet-side requesters and the single decoder instance.

---
 rtl/rs_decode_arbiter_if.sv | 35 +++
 rtl/rs_decode_arbiter.sv | 139 +++++++++++++
 tb/tb_rs_decode_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_decode_arbiter_if.sv
// Bundle of requester handshakes, result pulses and decoder control for rs_decode_arbiter.
// slave: arbiter side; master: requester/decoder side.
interface rs_decode_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 120
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [DW-1:0]         resp_error_pos;
    logic                  resp_with_error;
    logic                  resp_timeout;
    logic                  busy;
    logic [2:0]            grant_id;
    logic                  dec_decode_en;
    logic [DW-1:0]         dec_encoded_data;
    logic                  dec_clrn;
    logic                  dec_ready;
    logic                  dec_decode_complete;
    logic [DW-1:0]         dec_error_pos;
    logic                  dec_with_error;

    modport slave (
        input  req_valid, req_data, dec_ready, dec_decode_complete, dec_error_pos, dec_with_error,
        output req_ready, resp_valid, resp_error_pos, resp_with_error, resp_timeout, busy,
               grant_id, dec_decode_en, dec_encoded_data, dec_clrn
    );

    modport master (
        output req_valid, req_data, dec_ready, dec_decode_complete, dec_error_pos, dec_with_error,
        input  req_ready, resp_valid, resp_error_pos, resp_with_error, resp_timeout, busy,
               grant_id, dec_decode_en, dec_encoded_data, dec_clrn
    );
endinterface

// File: rtl/rs_decode_arbiter.sv
// Round-robin share of one RS decoder among NUM_REQ requesters; watchdog under RS_ARB_TIMEOUT_EN.
// Latency: grant G, decode_en G+1, response one cycle after decoder completion, next grant C+2.
// Backpressure: no grant while busy or while dec_ready=0; requesters hold valid/data until req_ready.
module rs_decode_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CW_BYTES       = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    rs_decode_arbiter_if.slave bus
);
    localparam int DW    = CW_BYTES * 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef RS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]         state;
    logic [2:0]         last_grant;
    logic [2:0]         grant_id_q;
    logic [2:0]         win_id;
    logic [DW-1:0]      win_data;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] resp_oh;
    logic               grant;
    logic [DW-1:0]      enc_q;
    logic [DW-1:0]      resp_pos_q;
    logic               resp_with_q;
    logic               resp_to_q;
    logic               clrn_q;
    logic               rst_seen;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_fire;
    int                 pick_d;
    int                 pick_best;

    // Winner is the valid requester at the smallest distance past last_grant.
    always_comb begin
        pick_best = NUM_REQ;
        pick_d    = 0;
        win_id    = '0;
        win_data  = '0;
        grant_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_d = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (bus.req_valid[i] && (pick_d < pick_best)) begin
                pick_best   = pick_d;
                win_id      = 3'(i);
                win_data    = bus.req_data[i*DW +: DW];
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        resp_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_oh[i] = (state == ST_RESP) && (grant_id_q == 3'(i));
        end
    end

    assign grant = (state == ST_IDLE) && bus.dec_ready && (|bus.req_valid);

    // A completion in the terminal WAIT cycle takes precedence over the watchdog.
    assign timeout_fire = TO_EN && (state == ST_WAIT)
                          && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                          && !bus.dec_decode_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 3'(NUM_REQ - 1);
            grant_id_q  <= '0;
            enc_q       <= '0;
            resp_pos_q  <= '0;
            resp_with_q <= 1'b0;
            resp_to_q   <= 1'b0;
            wait_cnt    <= '0;
            clrn_q      <= 1'b1;
            rst_seen    <= 1'b1;
        end else begin
            // Decoder clear is held low for the first cycle out of reset.
            rst_seen <= 1'b0;
            clrn_q   <= ~rst_seen;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        enc_q      <= win_data;
                        grant_id_q <= win_id;
                        state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.dec_decode_complete) begin
                        resp_pos_q  <= bus.dec_error_pos;
                        resp_with_q <= bus.dec_with_error;
                        resp_to_q   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timeout_fire) begin
                        resp_pos_q  <= '0;
                        resp_with_q <= 1'b0;
                        resp_to_q   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    last_grant <= grant_id_q;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready        = grant ? grant_oh : '0;
    assign bus.resp_valid       = resp_oh;
    assign bus.resp_error_pos   = resp_pos_q;
    assign bus.resp_with_error  = resp_with_q;
    assign bus.resp_timeout     = resp_to_q;
    assign bus.busy             = (state != ST_IDLE);
    assign bus.grant_id         = grant_id_q;
    assign bus.dec_decode_en    = (state == ST_LAUNCH);
    assign bus.dec_encoded_data = enc_q;
    assign bus.dec_clrn         = clrn_q & ~timeout_fire;
endmodule

// File: tb/tb_rs_decode_arbiter.sv
// Scoreboard bench for rs_decode_arbiter with a behavioural decoder model.
module tb_rs_decode_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int DW             = 120;
    localparam int TIMEOUT_CYCLES = 64;

    typedef struct {
        int            id;
        logic [DW-1:0] pos;
        logic          with_e;
        logic          tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_decode_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

    rs_decode_arbiter #(
        .NUM_REQ(NUM_REQ), .CW_BYTES(15), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    exp_t sb_q[$];
    int n_chk = 0, n_err = 0, n_resp = 0, n_push = 0;
    int cyc = 0, comp_cyc = -1;

    int            m_lat   = 30;
    logic [DW-1:0] m_pos   = '0;
    logic          m_with  = 1'b0;
    bit            m_never = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] pos, input logic w, input logic t);
        exp_t e;
        e.id = id; e.pos = pos; e.with_e = w; e.tmo = t;
        sb_q.push_back(e);
        n_push++;
    endtask

    // Returns at #1 inside the grant cycle, or with g=0 when the budget expires.
    task automatic wait_grant(output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (bus.req_ready !== '0) begin
                g = bus.req_ready;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        chk(nm, sb_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_pos"}, bus.resp_error_pos, 0);
        chk({tag, "_resp_with"}, bus.resp_with_error, 0);
        chk({tag, "_resp_tmo"}, bus.resp_timeout, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_grant_id"}, bus.grant_id, 0);
        chk({tag, "_decode_en"}, bus.dec_decode_en, 0);
        chk({tag, "_enc_data"}, bus.dec_encoded_data, 0);
        chk({tag, "_clrn"}, bus.dec_clrn, 1);
    endtask

    // Decoder model: completes m_lat cycles after the launch cycle, aborts on reset.
    initial begin : model
        bit aborted;
        bus.dec_decode_complete = 1'b0;
        bus.dec_error_pos       = '0;
        bus.dec_with_error      = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dec_decode_en === 1'b1 && !rst) begin
                aborted = 1'b0;
                for (int k = 0; k < m_lat && !aborted; k++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted && !m_never) begin
                    bus.dec_error_pos       = m_pos;
                    bus.dec_with_error      = m_with;
                    bus.dec_decode_complete = 1'b1;
                    comp_cyc                = cyc;
                    @(negedge clk);
                    bus.dec_decode_complete = 1'b0;
                    bus.dec_error_pos       = '0;
                    bus.dec_with_error      = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (bus.resp_valid !== '0) begin
                n_resp++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", bus.resp_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("resp_valid", bus.resp_valid, oh);
                    chk("resp_error_pos", bus.resp_error_pos, e.pos);
                    chk("resp_with_error", bus.resp_with_error, e.with_e);
                    chk("resp_timeout", bus.resp_timeout, e.tmo);
                    if (!e.tmo) chk("resp_latency", cyc, comp_cyc + 1);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [NUM_REQ-1:0] g;
        logic [DW-1:0]      d;
        int                 order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int                 first_low;
        bit                 saw_low;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("init");
        rst = 1'b0;
        @(negedge clk);
        chk("init_clrn_pulse", bus.dec_clrn, 0);
        @(negedge clk);
        chk("init_clrn_release", bus.dec_clrn, 1);

        // Single request on requester 2, clean codeword.
        for (int b = 0; b < 15; b++) d[b*8 +: 8] = 8'(b + 1);
        m_lat = 30; m_pos = '0; m_with = 1'b0;
        push_exp(2, '0, 1'b0, 1'b0);
        bus.req_data[2*DW +: DW] = d;
        bus.req_valid[2] = 1'b1;
        wait_grant(g);
        chk("single_grant", g, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        chk("single_ready_pulse", bus.req_ready, 0);
        chk("single_decode_en", bus.dec_decode_en, 1);
        chk("single_grant_id", bus.grant_id, 2);
        chk("single_enc_data", bus.dec_encoded_data, d);
        @(negedge clk);
        chk("single_decode_en_once", bus.dec_decode_en, 0);
        drain("single_drain");

        // Error result on requester 0: byte 5 = 0x3C.
        m_lat = 10; m_pos = '0; m_pos[47:40] = 8'h3C; m_with = 1'b1;
        push_exp(0, m_pos, 1'b1, 1'b0);
        bus.req_data[0*DW +: DW] = 120'h00FF_1234;
        bus.req_valid[0] = 1'b1;
        wait_grant(g);
        chk("err_grant", g, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        drain("err_drain");
        chk("err_pos_hold", bus.resp_error_pos, 120'h3C << 40);
        chk("err_with_hold", bus.resp_with_error, 1);

        // Back-pressure: no grant while dec_ready is low.
        m_lat = 5; m_pos = '0; m_with = 1'b0;
        bus.dec_ready = 1'b0;
        bus.req_data[1*DW +: DW] = 120'hBEEF;
        bus.req_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_no_grant", bus.req_ready, 0);
        end
        chk("bp_not_busy", bus.busy, 0);
        push_exp(1, '0, 1'b0, 1'b0);
        bus.dec_ready = 1'b1;
        #1;
        chk("bp_grant_on_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        chk("bp_grant_id", bus.grant_id, 1);
        drain("bp_drain");

        // Reset during WAIT aborts with no response.
        m_lat = 40;
        bus.req_data[3*DW +: DW] = 120'h77;
        bus.req_valid[3] = 1'b1;
        wait_grant(g);
        chk("rst_grant", g, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (10) @(negedge clk);
        chk("rst_busy_in_wait", bus.busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_clrn_pulse", bus.dec_clrn, 0);
        @(negedge clk);
        chk("midrst_clrn_release", bus.dec_clrn, 1);

        // Stray completion in IDLE is ignored.
        bus.dec_decode_complete = 1'b1;
        @(negedge clk);
        bus.dec_decode_complete = 1'b0;
        chk("stray_complete_busy", bus.busy, 0);
        @(negedge clk);
        chk("stray_complete_resp", bus.resp_valid, 0);

        // Fairness: all four continuously valid, rotation starts at 0 after reset.
        m_lat = 3; m_pos = '0; m_with = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DW +: DW] = DW'(160 + i);
        bus.req_valid = '1;
        for (int t = 0; t < 8; t++) begin
            wait_grant(g);
            chk("fair_grant", g, 4'b0001 << order[t]);
            push_exp(order[t], '0, 1'b0, 1'b0);
            @(negedge clk);
            chk("fair_enc_data", bus.dec_encoded_data, DW'(160 + order[t]));
        end
        bus.req_valid = '0;
        drain("fair_drain");

`ifdef RS_ARB_TIMEOUT_EN
        // Decoder never completes: watchdog clears it at WAIT cycle 64.
        m_never = 1'b1; m_lat = 1;
        push_exp(0, '0, 1'b0, 1'b1);
        bus.req_valid[0] = 1'b1;
        wait_grant(g);
        chk("to_grant", g, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        first_low = -1;
        for (int k = 1; k <= 100 && first_low < 0; k++) begin
            @(negedge clk);
            if (bus.dec_clrn === 1'b0) first_low = k;
        end
        chk("to_clrn_cycle", first_low, TIMEOUT_CYCLES);
        drain("to_drain");

        // Completion on the terminal cycle wins over the watchdog.
        m_never = 1'b0; m_lat = TIMEOUT_CYCLES;
        m_pos = '0; m_pos[15:8] = 8'hAB; m_with = 1'b1;
        push_exp(1, m_pos, 1'b1, 1'b0);
        bus.req_valid[1] = 1'b1;
        wait_grant(g);
        chk("to_race_grant", g, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        saw_low = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYCLES + 2; k++) begin
            @(negedge clk);
            if (bus.dec_clrn === 1'b0) saw_low = 1'b1;
        end
        chk("to_race_no_clear", saw_low, 0);
        drain("to_race_drain");
`endif

        repeat (3) @(negedge clk);
        chk("resp_count", n_resp, n_push);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
